// File: rtl/cmsdk_mcu_clkrst_pkg.sv
// Shared constants for the Cortex-M0 MCU clock/reset sequencer: FSM state
// encodings, RSTINFO bit positions and the width of the stretch counters.
package cmsdk_mcu_clkrst_pkg;

  localparam logic [2:0] ST_POR      = 3'd0;
  localparam logic [2:0] ST_DBG_REL  = 3'd1;
  localparam logic [2:0] ST_SYS_HOLD = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_SYS_RST  = 3'd4;

  localparam int RSTINFO_SYSRESET = 0;
  localparam int RSTINFO_LOCKUP   = 1;
  localparam int RSTINFO_WDOG     = 2;

  // Wide enough for the largest stretch value (255).
  localparam int CNT_W = 8;

endpackage

// File: rtl/cmsdk_mcu_clkrst_seq_if.sv
// Request/status bundle between the clock/reset sequencer and the MCU core side.
// RSTINFO/RSTINFOCLR exist only when CMSDK_MCU_RSTINFO_EN is defined.
interface cmsdk_mcu_clkrst_seq_if #(
  parameter int NUM_PRST   = 4,
  parameter int PCLK_DIV_W = 4
);
  logic                  SLEEPDEEP;
  logic                  SYSRESETREQ;
  logic                  DBGRESETREQ;
  logic                  LOCKUP;
  logic                  LOCKUPRESET;
  logic                  WDOGRESREQ;
  logic [NUM_PRST-1:0]   PRSTREQ;
  logic [PCLK_DIV_W-1:0] PCLKDIV;
  logic                  RSTBYPASS;

  logic                  PCLKEN;
  logic                  PORESETn;
  logic                  DBGRESETn;
  logic                  HRESETn;
  logic [NUM_PRST-1:0]   PRESETn;
  logic [2:0]            SEQSTATE;
`ifdef CMSDK_MCU_RSTINFO_EN
  logic [2:0]            RSTINFO;
  logic                  RSTINFOCLR;
`endif

  modport master (
    output SLEEPDEEP, SYSRESETREQ, DBGRESETREQ, LOCKUP, LOCKUPRESET, WDOGRESREQ,
           PRSTREQ, PCLKDIV, RSTBYPASS,
    input  PCLKEN, PORESETn, DBGRESETn, HRESETn, PRESETn, SEQSTATE
`ifdef CMSDK_MCU_RSTINFO_EN
    , output RSTINFOCLR, input RSTINFO
`endif
  );

  modport slave (
    input  SLEEPDEEP, SYSRESETREQ, DBGRESETREQ, LOCKUP, LOCKUPRESET, WDOGRESREQ,
           PRSTREQ, PCLKDIV, RSTBYPASS,
    output PCLKEN, PORESETn, DBGRESETn, HRESETn, PRESETn, SEQSTATE
`ifdef CMSDK_MCU_RSTINFO_EN
    , input RSTINFOCLR, output RSTINFO
`endif
  );

endinterface

// File: rtl/cmsdk_mcu_pclk_div.sv
// PCLKEN generator: one-cycle enable every div+1 clocks. The ratio is only
// re-sampled at count 0, so a mid-period change never shortens a period.
module cmsdk_mcu_pclk_div #(
  parameter int PCLK_DIV_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PCLK_DIV_W-1:0] div,
  output logic                  pclken
);

  logic [PCLK_DIV_W-1:0] cnt;
  logic [PCLK_DIV_W-1:0] div_q;
  logic [PCLK_DIV_W-1:0] lim;
  logic                  wrap;

  // At count 0 the live input sets the period; afterwards the latched copy does.
  assign lim  = (cnt == '0) ? div : div_q;
  assign wrap = (cnt == lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      div_q  <= '0;
      pclken <= 1'b0;
    end else begin
      cnt    <= wrap ? '0 : cnt + 1'b1;
      pclken <= wrap;
      if (cnt == '0) div_q <= div;
    end
  end

endmodule

// File: rtl/cmsdk_mcu_clkrst_seq.sv
// Cortex-M0 MCU clock/reset sequencer: reset synchroniser, POR/system/peripheral
// reset FSM, PCLKEN divider. Optional reset-cause register: CMSDK_MCU_RSTINFO_EN.
module cmsdk_mcu_clkrst_seq
  import cmsdk_mcu_clkrst_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int RST_STRETCH = 4,
  parameter int PCLK_DIV_W  = 4,
  parameter int NUM_PRST    = 4
) (
  input  logic XTAL1,
  input  logic NRST,
  output logic XTAL2,
  output logic FCLK,
  output logic PCLK,
  cmsdk_mcu_clkrst_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(RST_STRETCH - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   reset_n;
  logic [2:0]             state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [CNT_W-1:0]       pcnt [NUM_PRST];
  logic [NUM_PRST-1:0]    prst_q;
  logic                   dbg_q, hrst_q, pclken, lockup_req, sysreq;

  assign XTAL2 = ~(XTAL1 | bus.SLEEPDEEP);
  assign FCLK  = XTAL1;
  assign PCLK  = XTAL1;

  // NOTE: sequential state always uses <=, so every flop samples pre-edge values.
  always_ff @(posedge XTAL1 or negedge NRST) begin
    if (!NRST) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end
  assign reset_n = sync_q[SYNC_STAGES-1];

  assign lockup_req = bus.LOCKUP & bus.LOCKUPRESET;
  assign sysreq     = bus.SYSRESETREQ | lockup_req | bus.WDOGRESREQ;

  // NOTE: defaults first, so every path of the comb block assigns and no latch forms.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_POR:     state_nxt = ST_DBG_REL;
      ST_DBG_REL: begin
        cnt_nxt   = STRETCH_LOAD;
        state_nxt = ST_SYS_HOLD;
      end
      ST_SYS_HOLD: begin
        // Leave on the edge where the count lands on zero.
        if (cnt != '0)     cnt_nxt   = cnt - 1'b1;
        if (cnt <= 8'd1)   state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (sysreq) begin
          cnt_nxt   = STRETCH_LOAD;
          state_nxt = ST_SYS_RST;
        end
      end
      ST_SYS_RST: begin
        if (cnt != '0)     cnt_nxt   = cnt - 1'b1;
        else if (!sysreq)  state_nxt = ST_RUN;
      end
      default:             state_nxt = ST_POR;
    endcase
  end

  always_ff @(posedge XTAL1 or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_POR;
      cnt    <= '0;
      dbg_q  <= 1'b0;
      hrst_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dbg_q  <= ~bus.DBGRESETREQ;
      hrst_q <= (state_nxt == ST_RUN);
    end
  end

  // NOTE: the per-channel counter array is reset too; it gates when a channel may release.
  always_ff @(posedge XTAL1 or negedge reset_n) begin
    if (!reset_n) begin
      prst_q <= '0;
      for (int i = 0; i < NUM_PRST; i++) pcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PRST; i++) begin
        if (state_nxt != ST_RUN) begin
          prst_q[i] <= 1'b0;
          pcnt[i]   <= '0;
        end else if (state == ST_RUN && bus.PRSTREQ[i]) begin
          prst_q[i] <= 1'b0;
          pcnt[i]   <= STRETCH_LOAD;
        end else if (!prst_q[i]) begin
          if (pcnt[i] != '0)                 pcnt[i]   <= pcnt[i] - 1'b1;
          else if (state == ST_RUN && pclken) prst_q[i] <= 1'b1;
        end
      end
    end
  end

  cmsdk_mcu_pclk_div #(
    .PCLK_DIV_W (PCLK_DIV_W)
  ) u_pclk_div (
    .clk    (XTAL1),
    .rst_n  (reset_n),
    .div    (bus.PCLKDIV),
    .pclken (pclken)
  );

  assign bus.PCLKEN    = pclken;
  assign bus.SEQSTATE  = state;
  assign bus.PORESETn  = bus.RSTBYPASS ? NRST : reset_n;
  assign bus.DBGRESETn = bus.RSTBYPASS ? NRST : dbg_q;
  assign bus.HRESETn   = bus.RSTBYPASS ? NRST : hrst_q;
  assign bus.PRESETn   = bus.RSTBYPASS ? {NUM_PRST{NRST}} : prst_q;

`ifdef CMSDK_MCU_RSTINFO_EN
  logic [2:0] info_q, info_set;

  always_comb begin
    info_set = '0;
    if (state == ST_RUN && sysreq) begin
      info_set[RSTINFO_WDOG]     = bus.WDOGRESREQ;
      info_set[RSTINFO_LOCKUP]   = lockup_req;
      info_set[RSTINFO_SYSRESET] = bus.SYSRESETREQ;
    end
  end

  // Cleared only by power-on reset, so the cause survives the system reset it caused.
  always_ff @(posedge XTAL1 or negedge reset_n) begin
    if (!reset_n) info_q <= '0;
    else          info_q <= (bus.RSTINFOCLR ? 3'b000 : info_q) | info_set;
  end
  assign bus.RSTINFO = info_q;
`endif

endmodule

// File: tb/tb_cmsdk_mcu_clkrst_seq.sv
// Directed bench for cmsdk_mcu_clkrst_seq with default parameters; the
// RSTINFO checks are compiled in when CMSDK_MCU_RSTINFO_EN is defined.
module tb_cmsdk_mcu_clkrst_seq;

  logic clk = 1'b0;
  logic nrst;
  logic xtal2, fclk, pclk;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cmsdk_mcu_clkrst_seq_if #(.NUM_PRST(4), .PCLK_DIV_W(4)) bus ();

  cmsdk_mcu_clkrst_seq #(
    .SYNC_STAGES (3),
    .RST_STRETCH (4),
    .PCLK_DIV_W  (4),
    .NUM_PRST    (4)
  ) dut (
    .XTAL1 (clk),
    .NRST  (nrst),
    .XTAL2 (xtal2),
    .FCLK  (fclk),
    .PCLK  (pclk),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_en [8];
    int   n;
    exp_en = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    nrst             = 1'b1;
    bus.SLEEPDEEP    = 1'b0;
    bus.SYSRESETREQ  = 1'b0;
    bus.DBGRESETREQ  = 1'b0;
    bus.LOCKUP       = 1'b0;
    bus.LOCKUPRESET  = 1'b0;
    bus.WDOGRESREQ   = 1'b0;
    bus.PRSTREQ      = 4'b0000;
    bus.PCLKDIV      = 4'd0;
    bus.RSTBYPASS    = 1'b0;
`ifdef CMSDK_MCU_RSTINFO_EN
    bus.RSTINFOCLR   = 1'b0;
`endif
    #2 nrst = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_poresetn", bus.PORESETn, 1'b0);
    check("rst_dbgresetn", bus.DBGRESETn, 1'b0);
    check("rst_hresetn", bus.HRESETn, 1'b0);
    check("rst_presetn", bus.PRESETn, 4'h0);
    check("rst_pclken", bus.PCLKEN, 1'b0);
    check("rst_state", bus.SEQSTATE, 3'd0);

    // Power-up sequence, edges counted from NRST rising
    nrst = 1'b1;
    tick(); tick();
    check("por_e2_poresetn", bus.PORESETn, 1'b0);
    tick();
    check("por_e3_poresetn", bus.PORESETn, 1'b1);
    check("por_e3_dbgresetn", bus.DBGRESETn, 1'b0);
    tick();
    check("por_e4_dbgresetn", bus.DBGRESETn, 1'b1);
    check("por_e4_state", bus.SEQSTATE, 3'd1);
    check("por_e4_pclken", bus.PCLKEN, 1'b1);
    tick();
    check("por_e5_state", bus.SEQSTATE, 3'd2);
    repeat (2) tick();
    check("por_e7_hresetn", bus.HRESETn, 1'b0);
    tick();
    check("por_e8_hresetn", bus.HRESETn, 1'b1);
    check("por_e8_state", bus.SEQSTATE, 3'd3);
    check("por_e8_presetn", bus.PRESETn, 4'h0);
    tick();
    check("por_e9_presetn", bus.PRESETn, 4'hF);

    // Clock outputs
    check("fclk_high", fclk, 1'b1);
    check("pclk_high", pclk, 1'b1);
    check("xtal2_clk_high", xtal2, 1'b0);
    #5;
    check("xtal2_clk_low", xtal2, 1'b1);
    bus.SLEEPDEEP = 1'b1;
    #1 check("xtal2_sleepdeep", xtal2, 1'b0);
    bus.SLEEPDEEP = 1'b0;

    // Divider: ratio 4, changed to 2 mid-period, takes effect only after the wrap
    tick();
    bus.PCLKDIV = 4'd3;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 1) bus.PCLKDIV = 4'd1;
      check($sformatf("div_pclken_%0d", i), bus.PCLKEN, exp_en[i]);
    end
    bus.PCLKDIV = 4'd0;
    tick();
    check("div0_pclken_a", bus.PCLKEN, 1'b1);
    tick();
    check("div0_pclken_b", bus.PCLKEN, 1'b1);

    // Debug reset request: one-cycle latency, system reset untouched
    bus.DBGRESETREQ = 1'b1;
    tick();
    check("dbgreq_dbgresetn", bus.DBGRESETn, 1'b0);
    check("dbgreq_hresetn", bus.HRESETn, 1'b1);
    bus.DBGRESETREQ = 1'b0;
    tick();
    check("dbgreq_release", bus.DBGRESETn, 1'b1);

    // System reset request held for 10 cycles
    bus.SYSRESETREQ = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("sysreq_hresetn_%0d", i), bus.HRESETn, 1'b0);
      check($sformatf("sysreq_state_%0d", i), bus.SEQSTATE, 3'd4);
    end
    check("sysreq_presetn", bus.PRESETn, 4'h0);
    check("sysreq_dbgresetn", bus.DBGRESETn, 1'b1);
    bus.SYSRESETREQ = 1'b0;
    tick();
    check("sysreq_rel_hresetn", bus.HRESETn, 1'b1);
    check("sysreq_rel_state", bus.SEQSTATE, 3'd3);
    check("sysreq_rel_presetn", bus.PRESETn, 4'h0);
    tick();
    check("sysreq_rel_presetn2", bus.PRESETn, 4'hF);

    // Soft reset of channel 2, one-cycle request
    bus.PRSTREQ = 4'b0100;
    tick();
    bus.PRSTREQ = 4'b0000;
    check("soft_e0", bus.PRESETn, 4'b1011);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("soft_e%0d", i), bus.PRESETn, (i < 4) ? 4'b1011 : 4'b1111);
    end

    // Lockup without LOCKUPRESET is ignored
    bus.LOCKUP = 1'b1;
    tick(); tick();
    check("lockup_gated_hresetn", bus.HRESETn, 1'b1);
    check("lockup_gated_state", bus.SEQSTATE, 3'd3);

`ifdef CMSDK_MCU_RSTINFO_EN
    check("info_after_sysreq", bus.RSTINFO, 3'b001);
    bus.RSTINFOCLR = 1'b1;
    tick();
    bus.RSTINFOCLR = 1'b0;
    check("info_cleared", bus.RSTINFO, 3'b000);
`endif

    // Watchdog + lockup pulse with a simultaneous soft reset: system reset wins
    bus.LOCKUPRESET = 1'b1;
    bus.WDOGRESREQ  = 1'b1;
    bus.PRSTREQ     = 4'b0001;
    tick();
    bus.LOCKUP      = 1'b0;
    bus.LOCKUPRESET = 1'b0;
    bus.WDOGRESREQ  = 1'b0;
    bus.PRSTREQ     = 4'b0000;
    check("wdog_hresetn", bus.HRESETn, 1'b0);
    check("wdog_state", bus.SEQSTATE, 3'd4);
    check("wdog_presetn", bus.PRESETn, 4'h0);
`ifdef CMSDK_MCU_RSTINFO_EN
    check("info_wdog_lockup", bus.RSTINFO, 3'b110);
`endif
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("wdog_hold_%0d", i), bus.HRESETn, 1'b0);
    end
    tick();
    check("wdog_rel_hresetn", bus.HRESETn, 1'b1);
    tick();
    check("wdog_rel_presetn", bus.PRESETn, 4'hF);
`ifdef CMSDK_MCU_RSTINFO_EN
    check("info_survives", bus.RSTINFO, 3'b110);
    bus.RSTINFOCLR = 1'b1;
    tick();
    bus.RSTINFOCLR = 1'b0;
    check("info_clr", bus.RSTINFO, 3'b000);
`endif

    // Bypass: reset outputs follow NRST with no clock edge in between
    bus.RSTBYPASS = 1'b1;
    #1 check("byp_hi_outs", {bus.PORESETn, bus.DBGRESETn, bus.HRESETn, bus.PRESETn}, 7'h7F);
    nrst = 1'b0;
    #1 check("byp_lo_outs", {bus.PORESETn, bus.DBGRESETn, bus.HRESETn, bus.PRESETn}, 7'h00);
    check("byp_lo_state", bus.SEQSTATE, 3'd0);
    nrst = 1'b1;
    #1 check("byp_rise_outs", {bus.PORESETn, bus.DBGRESETn, bus.HRESETn, bus.PRESETn}, 7'h7F);
    bus.RSTBYPASS = 1'b0;
    #1 check("byp_off_hresetn", bus.HRESETn, 1'b0);

    // Restart after the mid-sequence reset: HRESETn rises on the 8th edge
    n = 0;
    while (bus.HRESETn !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("restart_edges", n, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmsdk_mcu_clkrst_seq.md
Name: cmsdk_mcu_clkrst_seq

Overview:
Parametrised second-generation clock/reset controller for the Cortex-M0 MCU subsystem.
- Synchronises the external reset with a configurable-depth synchroniser.
- Sequences debug, system and per-channel peripheral resets through an FSM with a programmable stretch counter.
- Generates PCLKEN from a run-time programmable divider.
- Adds a watchdog reset source and per-peripheral soft-reset channels.
- Sits between the board pins (XTAL1/NRST) and the core, PMU, AHB-to-APB bridge and APB peripherals.

Parameters:
- SYNC_STAGES, 3, reset synchroniser depth; legal range 2..4.
- RST_STRETCH, 4, cycles HRESETn/PRESETn are held low after any reset request; legal range 1..255.
- PCLK_DIV_W, 4, width of PCLKDIV; PCLK divide ratio is PCLKDIV+1.
- NUM_PRST, 4, number of peripheral reset channels; legal range 1..8.

Ports:
- XTAL1  input  1  clock source; the only clock in the block.
- NRST  input  1  external reset; asynchronous assertion, active-low.
- SLEEPDEEP  input  1  deep-sleep status; stops the crystal feedback.
- SYSRESETREQ  input  1  core system reset request.
- DBGRESETREQ  input  1  debug reset request.
- LOCKUP  input  1  core lockup status.
- LOCKUPRESET  input  1  enables reset on lockup.
- WDOGRESREQ  input  1  watchdog reset request.
- PRSTREQ  input  NUM_PRST  per-channel peripheral soft-reset request, level-sensitive.
- PCLKDIV  input  PCLK_DIV_W  PCLK divide-1 value.
- RSTBYPASS  input  1  test mode; all reset outputs follow NRST.
- XTAL2  output  1  equals ~(XTAL1 | SLEEPDEEP).
- FCLK  output  1  free-running clock, equals XTAL1.
- PCLK  output  1  equals XTAL1.
- PCLKEN  output  1  one-cycle enable, every PCLKDIV+1 cycles.
- PORESETn  output  1  synchronised power-on reset.
- DBGRESETn  output  1  debug reset.
- HRESETn  output  1  system/AHB reset.
- PRESETn  output  NUM_PRST  per-channel APB reset.
- SEQSTATE  output  3  current FSM state, for debug observation.

Behaviour:
- Synchroniser: an SYNC_STAGES-deep shift register of 1s. NRST low clears it asynchronously. reset_n is the last stage. PORESETn = reset_n, so it deasserts SYNC_STAGES edges after NRST rises.
- All internal registers reset asynchronously on reset_n low. All reset outputs are registered, except PORESETn and the RSTBYPASS path.
- Reset values: DBGRESETn=0, HRESETn=0, PRESETn=all 0, PCLKEN=0, SEQSTATE=POR.
- sysreq = SYSRESETREQ | (LOCKUP & LOCKUPRESET) | WDOGRESREQ.
- FSM states:
  - POR (0): leaves on the first edge with reset_n=1, to DBG_REL.
  - DBG_REL (1): DBGRESETn goes 1. Loads cnt=RST_STRETCH-1. Goes to SYS_HOLD.
  - SYS_HOLD (2): cnt decrements. At cnt==0 goes to RUN.
  - RUN (3): HRESETn=1. If sysreq=1, goes to SYS_RST and loads cnt=RST_STRETCH-1. HRESETn and PRESETn go low on the next edge.
  - SYS_RST (4): cnt decrements, saturating at 0. Leaves to RUN only when cnt==0 and sysreq==0. A held request keeps the block in reset.
- PRESETn[i]: 0 while HRESETn=0. Releases on the first PCLKEN=1 edge after HRESETn=1, so peripheral resets release aligned to an APB clock.
- Soft reset: PRSTREQ[i] high in RUN pulls PRESETn[i] low on the next edge and loads a per-channel counter with RST_STRETCH-1. The channel releases on the first PCLKEN edge after the counter reaches 0 with PRSTREQ[i] low. Other channels are unaffected.
- Simultaneous sysreq and PRSTREQ: sysreq wins. Channel counters are cleared.
- DBGRESETn after POR: registered ~DBGRESETREQ (1-cycle latency), independent of the FSM. It is not affected by sysreq.
- Divider: PCLKDIV is sampled only when the divider count is 0, so a change never produces a short PCLKEN period.
  - PCLKDIV=0: PCLKEN is constantly 1 after POR.
  - PCLKDIV=N: PCLKEN is high 1 cycle in every N+1.
  - The counter wraps from PCLKDIV to 0 without overflow. The divider keeps running in SYS_RST.
- RSTBYPASS=1: PORESETn, DBGRESETn, HRESETn and all PRESETn bits equal NRST combinationally. Internal state still runs.
- NRST low mid-sequence: every state is abandoned immediately and the FSM returns to POR.

Optional Feature:
CMSDK_MCU_RSTINFO_EN.
- Defined: adds port RSTINFO output 3 = {wdog, lockup, sysreset}, plus input RSTINFOCLR.
  - Each bit is set sticky on RUN->SYS_RST according to the cause; several bits may set at once.
  - Bits are cleared by RSTINFOCLR=1 for one cycle. A set in the same cycle wins over the clear.
  - The register resets only on PORESETn, not on HRESETn.
- Undefined: the ports and the register are absent.

Decomposition:
- Shared package (cmsdk_mcu_clkrst_pkg): FSM state localparams POR..SYS_RST (3-bit) and the RSTINFO bit indices.
- Sub-module cmsdk_mcu_pclk_div: the divider counter and PCLKEN generation, parametrised by PCLK_DIV_W.

Test Plan:
- NRST 0->1 with defaults → PORESETn rises after 3 edges, DBGRESETn 1 edge later, HRESETn 4 edges after that. PRESETn=4'hF on the next PCLKEN.
- PCLKDIV=3, changed to 1 mid-period → PCLKEN period stays 4 until the count wraps, then becomes 2. No pulse narrower than 1 cycle and no gap shorter than PCLKDIV.
- SYSRESETREQ held high for 10 cycles in RUN → HRESETn low 1 edge later, stays low until 1 edge after the request drops, SEQSTATE=4 throughout.
- PRSTREQ=4'b0100 pulsed 1 cycle, PCLKDIV=0 → only PRESETn[2] low for exactly 4 cycles, others stay 1.
- RSTBYPASS=1, NRST toggled → all reset outputs track NRST with zero latency.
- With CMSDK_MCU_RSTINFO_EN: WDOGRESREQ and LOCKUP&LOCKUPRESET together → RSTINFO=3'b110, survives HRESETn, clears on RSTINFOCLR.
